// File: rtl/sopc_irq_pkg.sv
// Shared constants and types for the SOPC interrupt controller: register map,
// widths and the packed priority-vector format driven to the CPU.
package sopc_irq_pkg;

  localparam int MAX_IRQ = 16;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int IDX_W   = 4;
  localparam int VEC_W   = IDX_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_PENDING = 3'd0;
  localparam addr_t ADDR_MASK    = 3'd1;
  localparam addr_t ADDR_EDGE    = 3'd2;
  localparam addr_t ADDR_ACTIVE  = 3'd3;
  localparam addr_t ADDR_VECTOR  = 3'd4;
  localparam addr_t ADDR_ACK     = 3'd5;
  localparam addr_t ADDR_RAW     = 3'd6;
  localparam addr_t ADDR_SWSET   = 3'd7;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } vec_t;

  function automatic logic [DATA_W-1:0] pack_vector(input vec_t v);
    return {{(DATA_W-VEC_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/sopc_irq_controller_if.sv
// Avalon-MM slave bus bundle for the interrupt controller register file.
interface sopc_irq_controller_if;
  import sopc_irq_pkg::*;

  logic              chipselect;
  addr_t             address;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect,
    output address,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  address,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the lowest-index asserted request wins.
module irq_prio_enc
  import sopc_irq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sopc_irq_controller.sv
// Avalon-MM interrupt controller: per-line level/edge capture, masking, a
// lowest-index-first priority vector and a registered combined irq.
module sopc_irq_controller
  import sopc_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sopc_irq_controller_if.slave  bus,
  input  logic [NUM_IRQ-1:0]    irq_in,
  output logic                  irq,
  output logic [VEC_W-1:0]      irq_vector
);

  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_mode_q, edge_mode_d;
  logic [NUM_IRQ-1:0] latch_q, latch_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               irq_q, irq_d;
  vec_t               vector_q, vector_d;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] ack_onehot;
  logic [NUM_IRQ-1:0] set_bits;
  logic [NUM_IRQ-1:0] clr_bits;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_index;
  vec_t               vector_now;
  logic [DATA_W-1:0]  read_mux;
  logic               unused_wdata;

  function automatic logic [DATA_W-1:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wr_bits      = bus.writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.writedata;
  assign edge_det     = irq_in & ~prev_q;

  irq_prio_enc #(
    .WIDTH (NUM_IRQ)
  ) u_prio_enc (
    .req   (active),
    .valid (enc_valid),
    .index (enc_index)
  );

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pending[i] = edge_mode_q[i] ? latch_q[i] : irq_in[i];
    end
    active           = pending & mask_q;
    vector_now.valid = enc_valid;
    vector_now.index = enc_index;

    // ACK indices at or beyond NUM_IRQ decode to no line at all.
    ack_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_onehot[i] = (bus.writedata[IDX_W-1:0] == IDX_W'(i));
    end
  end

  always_comb begin
    mask_d      = mask_q;
    edge_mode_d = edge_mode_q;
    set_bits    = edge_det & edge_mode_q;
    clr_bits    = '0;

    if (wr_en) begin
      case (bus.address)
        ADDR_PENDING: clr_bits    = wr_bits;
        ADDR_MASK:    mask_d      = wr_bits;
        ADDR_EDGE:    edge_mode_d = wr_bits;
        ADDR_ACK:     clr_bits    = ack_onehot;
        ADDR_SWSET:   set_bits    = set_bits | (wr_bits & edge_mode_q);
        default:      ;
      endcase
    end

    // Set wins over clear so a fresh edge is never lost to a racing ack.
    latch_d = (set_bits | (latch_q & ~clr_bits)) & edge_mode_q;
    prev_d  = irq_in;
    irq_d   = enc_valid;
    vector_d = vector_now;

    case (bus.address)
      ADDR_PENDING: read_mux = zext(pending);
      ADDR_MASK:    read_mux = zext(mask_q);
      ADDR_EDGE:    read_mux = zext(edge_mode_q);
      ADDR_ACTIVE:  read_mux = zext(active);
      ADDR_VECTOR:  read_mux = pack_vector(vector_now);
      ADDR_RAW:     read_mux = zext(irq_in);
      default:      read_mux = '0;
    endcase
    readdata_d = bus.chipselect ? read_mux : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q      <= '0;
      edge_mode_q <= '0;
      latch_q     <= '0;
      prev_q      <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      vector_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      latch_q     <= latch_d;
      prev_q      <= prev_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      vector_q    <= vector_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;
  assign irq_vector   = vector_q;

endmodule

// File: tb/tb_sopc_irq_controller.sv
// Directed plus randomized bench for sopc_irq_controller, checked every cycle
// against a per-line behavioural model of the register map.
module tb_sopc_irq_controller;
  import sopc_irq_pkg::*;

  localparam int NUM_IRQ = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq;
  logic [4:0]         irq_vector;

  int checks   = 0;
  int failures = 0;

  logic [NUM_IRQ-1:0] cur_irq;
  bit                 m_mask  [NUM_IRQ];
  bit                 m_edge  [NUM_IRQ];
  bit                 m_latch [NUM_IRQ];
  bit                 m_prev  [NUM_IRQ];
  logic [15:0]        exp_rd;
  logic               exp_irq;
  logic [4:0]         exp_vec;

  sopc_irq_controller_if bus();

  sopc_irq_controller #(
    .NUM_IRQ (NUM_IRQ)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".readdata"}, bus.readdata, exp_rd);
    checkValue({tag, ".irq"}, {15'd0, irq}, {15'd0, exp_irq});
    checkValue({tag, ".vector"}, {11'd0, irq_vector}, {11'd0, exp_vec});
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_mask[i]  = 1'b0;
      m_edge[i]  = 1'b0;
      m_latch[i] = 1'b0;
      m_prev[i]  = 1'b0;
    end
    exp_rd  = '0;
    exp_irq = 1'b0;
    exp_vec = '0;
  endtask

  // One clock: drive the bus, predict the registered outputs, then advance.
  task automatic applyStimulus(input bit cs, input bit [2:0] a, input bit wr_n, input bit [15:0] wd);
    int          first;
    bit [15:0]   pend_w;
    bit [15:0]   act_w;
    bit [15:0]   raw_w;
    bit [15:0]   rd;
    bit          wr;
    bit          set_i;
    bit          clr_i;
    bit          n_mask  [NUM_IRQ];
    bit          n_edge  [NUM_IRQ];
    bit          n_latch [NUM_IRQ];

    bus.chipselect = cs;
    bus.address    = a;
    bus.write_n    = wr_n;
    bus.writedata  = wd;
    irq_in         = cur_irq;

    pend_w = '0;
    act_w  = '0;
    raw_w  = '0;
    first  = -1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      raw_w[i]  = cur_irq[i];
      pend_w[i] = m_edge[i] ? m_latch[i] : cur_irq[i];
      act_w[i]  = pend_w[i] && m_mask[i];
      if (act_w[i] && first < 0) first = i;
    end

    rd = '0;
    if (cs) begin
      case (a)
        3'd0: rd = pend_w;
        3'd1: for (int i = 0; i < NUM_IRQ; i++) rd[i] = m_mask[i];
        3'd2: for (int i = 0; i < NUM_IRQ; i++) rd[i] = m_edge[i];
        3'd3: rd = act_w;
        3'd4: rd = (first >= 0) ? 16'(16 + first) : 16'd0;
        3'd6: rd = raw_w;
        default: rd = '0;
      endcase
    end

    wr = cs && !wr_n;
    for (int i = 0; i < NUM_IRQ; i++) begin
      n_mask[i] = (wr && a == 3'd1) ? wd[i] : m_mask[i];
      n_edge[i] = (wr && a == 3'd2) ? wd[i] : m_edge[i];
      set_i = (m_edge[i] && cur_irq[i] && !m_prev[i]) ||
              (wr && a == 3'd7 && wd[i] && m_edge[i]);
      clr_i = (wr && a == 3'd0 && wd[i]) ||
              (wr && a == 3'd5 && int'(wd[3:0]) == i);
      n_latch[i] = !m_edge[i] ? 1'b0 : (set_i ? 1'b1 : (clr_i ? 1'b0 : m_latch[i]));
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_mask[i]  = n_mask[i];
      m_edge[i]  = n_edge[i];
      m_latch[i] = n_latch[i];
      m_prev[i]  = cur_irq[i];
    end

    @(posedge clk);
    #1;
    exp_rd  = rd;
    exp_irq = (first >= 0);
    exp_vec = (first >= 0) ? 5'(16 + first) : 5'd0;
  endtask

  task automatic writeReg(input bit [2:0] a, input bit [15:0] d, input string tag);
    applyStimulus(1'b1, a, 1'b0, d);
    checkOutput(tag);
  endtask

  task automatic readReg(input bit [2:0] a, input string tag);
    applyStimulus(1'b1, a, 1'b1, 16'd0);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 3'd0, 1'b1, 16'd0);
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          cs;
    bit          wr_n;
    bit [2:0]    a;
    bit [15:0]   wd;

    $display("[TB] start");
    reset_n        = 1'b0;
    cur_irq        = '0;
    irq_in         = '0;
    bus.chipselect = 1'b0;
    bus.address    = '0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset.readdata", bus.readdata, 16'h0000);
    checkValue("reset.irq", {15'd0, irq}, 16'h0000);
    checkValue("reset.vector", {11'd0, irq_vector}, 16'h0000);
    reset_n = 1'b1;

    readReg(ADDR_MASK, "reset.mask");
    checkValue("reset.mask_read", bus.readdata, 16'h0000);
    readReg(ADDR_EDGE, "reset.edge");
    checkValue("reset.edge_read", bus.readdata, 16'h0000);

    writeReg(ADDR_MASK, 16'h0001, "level.mask");
    writeReg(ADDR_EDGE, 16'h0000, "level.edge");
    cur_irq = 8'h01;
    idle("level.rise");
    checkValue("level.irq_high", {15'd0, irq}, 16'h0001);
    cur_irq = 8'h00;
    idle("level.fall");
    checkValue("level.irq_low", {15'd0, irq}, 16'h0000);

    writeReg(ADDR_EDGE, 16'h0004, "edge.edge");
    writeReg(ADDR_MASK, 16'h0004, "edge.mask");
    cur_irq = 8'h04;
    idle("edge.pulse");
    checkValue("edge.irq_not_yet", {15'd0, irq}, 16'h0000);
    cur_irq = 8'h00;
    idle("edge.after");
    checkValue("edge.irq_high", {15'd0, irq}, 16'h0001);
    readReg(ADDR_PENDING, "edge.pending");
    checkValue("edge.pending_read", bus.readdata, 16'h0004);
    readReg(ADDR_VECTOR, "edge.vector");
    checkValue("edge.vector_read", bus.readdata, 16'h0012);
    checkValue("edge.irq_vector", {11'd0, irq_vector}, 16'h0012);
    writeReg(ADDR_ACK, 16'h0002, "edge.ack");
    idle("edge.post_ack");
    checkValue("edge.irq_cleared", {15'd0, irq}, 16'h0000);
    readReg(ADDR_PENDING, "edge.pending2");
    checkValue("edge.pending_cleared", bus.readdata, 16'h0000);

    writeReg(ADDR_EDGE, 16'h0000, "prio.edge");
    writeReg(ADDR_MASK, 16'h00FF, "prio.mask");
    cur_irq = 8'h28;
    idle("prio.both");
    checkValue("prio.vec_3", {11'd0, irq_vector}, 16'h0013);
    cur_irq = 8'h20;
    idle("prio.only5");
    checkValue("prio.vec_5", {11'd0, irq_vector}, 16'h0015);
    cur_irq = 8'h00;
    idle("prio.none");

    writeReg(ADDR_EDGE, 16'h0002, "race.edge");
    writeReg(ADDR_MASK, 16'h0002, "race.mask");
    cur_irq = 8'h02;
    idle("race.pulse1");
    cur_irq = 8'h00;
    idle("race.gap");
    checkValue("race.irq_set", {15'd0, irq}, 16'h0001);
    cur_irq = 8'h02;
    writeReg(ADDR_PENDING, 16'h0002, "race.w1c_edge");
    cur_irq = 8'h00;
    idle("race.after");
    checkValue("race.irq_kept", {15'd0, irq}, 16'h0001);
    readReg(ADDR_PENDING, "race.pending");
    checkValue("race.pending_kept", bus.readdata, 16'h0002);
    writeReg(ADDR_PENDING, 16'h0002, "race.w1c");
    idle("race.cleared");
    checkValue("race.irq_cleared", {15'd0, irq}, 16'h0000);

    writeReg(ADDR_MASK, 16'h0000, "sw.mask");
    writeReg(ADDR_EDGE, 16'h0080, "sw.edge");
    writeReg(ADDR_SWSET, 16'h0081, "sw.set");
    readReg(ADDR_PENDING, "sw.pending");
    checkValue("sw.pending_read", bus.readdata, 16'h0080);
    writeReg(ADDR_EDGE, 16'h0000, "sw.level");
    idle("sw.settle");
    cur_irq = 8'h80;
    readReg(ADDR_PENDING, "sw.follow_hi");
    checkValue("sw.pending_hi", bus.readdata, 16'h0080);
    cur_irq = 8'h00;
    readReg(ADDR_PENDING, "sw.follow_lo");
    checkValue("sw.pending_lo", bus.readdata, 16'h0000);
    writeReg(ADDR_EDGE, 16'h0080, "sw.edge_again");
    readReg(ADDR_PENDING, "sw.latch_gone");
    checkValue("sw.latch_cleared", bus.readdata, 16'h0000);

    writeReg(ADDR_MASK, 16'h0080, "rst.mask");
    writeReg(ADDR_SWSET, 16'h0080, "rst.set");
    readReg(ADDR_ACTIVE, "rst.active");
    checkValue("rst.irq_before", {15'd0, irq}, 16'h0001);
    checkValue("rst.active_before", bus.readdata, 16'h0080);
    #3;
    reset_n = 1'b0;
    #1;
    checkValue("rst.async_readdata", bus.readdata, 16'h0000);
    checkValue("rst.async_irq", {15'd0, irq}, 16'h0000);
    checkValue("rst.async_vector", {11'd0, irq_vector}, 16'h0000);
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    readReg(ADDR_EDGE, "rst.edge");
    checkValue("rst.edge_read", bus.readdata, 16'h0000);
    readReg(ADDR_PENDING, "rst.pending");
    checkValue("rst.pending_read", bus.readdata, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      cur_irq = NUM_IRQ'($urandom);
      cs      = ($urandom_range(0, 3) != 0);
      wr_n    = ($urandom_range(0, 2) != 0);
      a       = 3'($urandom);
      wd      = 16'($urandom);
      applyStimulus(cs, a, wr_n, wd);
      checkOutput("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
